// File: rtl/fp_mult_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fp_mult_pkg
// Brief    : Shared constants, state encoding and helpers for the
//            floating-point multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package fp_mult_pkg;

    // Default mantissa width (also shift-add iteration count).
    localparam int c_default_width = 4;

    // Explicit 3-bit state encoding; codes 6 and 7 are unused.
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_iter = 3'd2;
    localparam logic [2:0] c_st_exp  = 3'd3;
    localparam logic [2:0] c_st_norm = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE = c_st_idle,
        ST_LOAD = c_st_load,
        ST_ITER = c_st_iter,
        ST_EXP  = c_st_exp,
        ST_NORM = c_st_norm,
        ST_DONE = c_st_done
    } state_t;

    // Counter width able to hold the value w without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_mult_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : fp_mult_sequencer_if
// Brief     : Request/response handshake between the operand source and
//             the multiply sequencer.
// Revision  : 1.0 - initial release
// ============================================================================
interface fp_mult_sequencer_if;

    logic req_valid;
    logic req_ready;
    logic resp_valid;
    logic resp_ready;
    logic zero_result;

    // Requester side: presents operands, consumes the result.
    modport master (
        output req_valid,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  zero_result
    );

    // Sequencer side.
    modport slave (
        input  req_valid,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output zero_result
    );

endinterface
`default_nettype wire

// File: rtl/fp_mult_counter.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_counter
// Brief    : Clear/increment counter that saturates at MAX_VAL instead of
//            wrapping. Clear has priority over increment.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_counter #(
    parameter int CNT_W   = 3,
    parameter int MAX_VAL = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             i_clr,
    input  wire logic             i_inc,
    output logic [CNT_W-1:0]      o_count
);

    localparam logic [CNT_W-1:0] c_max = CNT_W'(MAX_VAL);

    logic [CNT_W-1:0] r_count;

    // Count register: async clear on reset, sync clear, saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fp_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fp_mult_sequencer
// Brief    : Control sequencer for a shift-add floating-point mantissa
//            multiplier: operand load, WIDTH shift-add iterations, exponent
//            add, normalisation and result handshake.
// Revision : 1.0 - initial release
// ============================================================================
module fp_mult_sequencer
    import fp_mult_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  wire logic          int_clk,
    input  wire logic          rst_n,
    fp_mult_sequencer_if.slave bus,
    input  wire logic          mult_lsb,
    input  wire logic          norm_msb,
    output logic               start,
    output logic               load_en,
    output logic               add_en,
    output logic               shift_en,
    output logic               exp_en,
    output logic               norm_shift
);

    localparam int                 c_cnt_w     = cnt_width(WIDTH);
    localparam logic [c_cnt_w-1:0] c_cnt_max   = c_cnt_w'(WIDTH);
    localparam logic [c_cnt_w-1:0] c_icnt_last = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cnt_w-1:0] w_icnt;
    logic [c_cnt_w-1:0] w_ncnt;
    logic               w_icnt_clr;
    logic               w_icnt_inc;
    logic               w_ncnt_clr;
    logic               w_ncnt_inc;
    logic               w_zero_capture;
    logic               w_zero_clr;
    logic               r_zero_result;
    logic               w_req_ready;
    logic               w_resp_valid;
    logic               w_zero_result;

    // Iteration counter: cleared in LOAD, stepped once per ITER cycle.
    fp_mult_counter #(
        .CNT_W   (c_cnt_w),
        .MAX_VAL (WIDTH)
    ) u_icnt (
        .clk     (int_clk),
        .rst_n   (rst_n),
        .i_clr   (w_icnt_clr),
        .i_inc   (w_icnt_inc),
        .o_count (w_icnt)
    );

    // Normalise counter: cleared in EXP, stepped once per normalise shift.
    fp_mult_counter #(
        .CNT_W   (c_cnt_w),
        .MAX_VAL (WIDTH)
    ) u_ncnt (
        .clk     (int_clk),
        .rst_n   (rst_n),
        .i_clr   (w_ncnt_clr),
        .i_inc   (w_ncnt_inc),
        .o_count (w_ncnt)
    );

    // State register; reset abandons any operation in flight.
    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Zero flag: captured on NORM exit, held through DONE.
    always_ff @(posedge int_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_zero_result <= 1'b0;
        end else if (w_zero_clr) begin
            r_zero_result <= 1'b0;
        end else if (w_zero_capture) begin
            // Exiting with MSB still clear means the shift budget ran out:
            // the product has no set bit.
            r_zero_result <= ~norm_msb;
        end
    end

    // Next-state and output decode. Outputs follow the registered state;
    // add_en (from mult_lsb) and norm_shift (from norm_msb) must react in
    // the same cycle, so those two inputs are the only combinational paths.
    always_comb begin
        w_state_next   = r_state;
        w_req_ready    = 1'b0;
        w_resp_valid   = 1'b0;
        w_zero_result  = 1'b0;
        start          = 1'b0;
        load_en        = 1'b0;
        add_en         = 1'b0;
        shift_en       = 1'b0;
        exp_en         = 1'b0;
        norm_shift     = 1'b0;
        w_icnt_clr     = 1'b0;
        w_icnt_inc     = 1'b0;
        w_ncnt_clr     = 1'b0;
        w_ncnt_inc     = 1'b0;
        w_zero_capture = 1'b0;
        w_zero_clr     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_next = ST_LOAD;
                end
            end

            ST_LOAD: begin
                start        = 1'b1;
                load_en      = 1'b1;
                w_icnt_clr   = 1'b1;
                w_zero_clr   = 1'b1;
                w_state_next = ST_ITER;
            end

            ST_ITER: begin
                shift_en   = 1'b1;
                add_en     = mult_lsb;
                w_icnt_inc = 1'b1;
                if (w_icnt == c_icnt_last) begin
                    w_state_next = ST_EXP;
                end
            end

            ST_EXP: begin
                exp_en       = 1'b1;
                w_ncnt_clr   = 1'b1;
                w_state_next = ST_NORM;
            end

            ST_NORM: begin
                if (norm_msb || (w_ncnt == c_cnt_max)) begin
                    w_zero_capture = 1'b1;
                    w_state_next   = ST_DONE;
                end else begin
                    norm_shift = 1'b1;
                    w_ncnt_inc = 1'b1;
                end
            end

            ST_DONE: begin
                w_resp_valid  = 1'b1;
                w_zero_result = r_zero_result;
                if (bus.resp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                // Unused encodings recover to IDLE on the next edge.
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.resp_valid  = w_resp_valid;
    assign bus.zero_result = w_zero_result;

endmodule
`default_nettype wire
